// File: rtl/mult_funct3.sv
// Shared types for the multiplier sequencer: RISC-V M-extension funct3 codes,
// controller state encoding, and the operand sign-handling rules.
package mult_funct3;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011
  } mult_funct3_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SIGN,
    ST_PP,
    ST_REDUCE,
    ST_RESP
  } mult_ctrl_state_t;

  // rs1 is treated as signed by every op except mulhu.
  function automatic logic flip_rs1(input mult_funct3_t op, input logic msb);
    return (op != F3_MULHU) && msb;
  endfunction

  // rs2 is treated as signed only by mul/mulh.
  function automatic logic flip_rs2(input mult_funct3_t op, input logic msb);
    return ((op == F3_MUL) || (op == F3_MULH)) && msb;
  endfunction

endpackage

// File: rtl/mult_ctrl_if.sv
// Request/response handshake bundle between the issue stage (master) and the
// multiplier sequencer (slave).
interface mult_ctrl_if
  import mult_funct3::*;
#(
    parameter int DATA_W = 4
);

    logic                req_valid;
    logic                req_ready;
    mult_funct3_t        req_op;
    logic [DATA_W-1:0]   req_rs1;
    logic [DATA_W-1:0]   req_rs2;
    logic                resp_valid;
    logic                resp_ready;
    logic [DATA_W-1:0]   resp_data;

    modport master (
        output req_valid, req_op, req_rs1, req_rs2, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, resp_ready,
        output req_ready, resp_valid, resp_data
    );

endinterface

// File: rtl/mult_result_fix.sv
// Sign-corrects the unsigned magnitude product and selects the half the op
// returns (low half for mul, high half otherwise).
module mult_result_fix
    import mult_funct3::*;
#(
    parameter int DATA_W = 4
) (
    input  mult_funct3_t        op,
    input  logic                rs1_msb,
    input  logic                rs2_msb,
    input  logic [2*DATA_W-1:0] prod,
    output logic [DATA_W-1:0]   data
);

    logic                neg;
    logic [2*DATA_W-1:0] p;

    // Result is negative exactly when an odd number of operands were flipped.
    assign neg = flip_rs1(op, rs1_msb) ^ flip_rs2(op, rs2_msb);
    assign p   = neg ? -prod : prod;

    always_comb begin
        data = p[2*DATA_W-1:DATA_W];
        if (op == F3_MUL) begin
            data = p[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/mult_ctrl.sv
// Sequencer for the dadda multiplier datapath: accepts one request, steps the
// datapath strobes, and returns the sign-corrected result.
// Optional flush input enabled by defining MULT_CTRL_FLUSH_EN.
module mult_ctrl
    import mult_funct3::*;
#(
    parameter int DATA_W        = 4,
    parameter int REDUCE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    mult_ctrl_if.slave          bus,
    output logic [DATA_W-1:0]   dp_a,
    output logic [DATA_W-1:0]   dp_b,
    output logic                dp_compute_sign,
    output logic                dp_flip_rs1,
    output logic                dp_flip_rs2,
    output logic                dp_i_rdy,
    output logic                dp_mult_done,
    input  logic [2*DATA_W-1:0] dp_prod,
    output logic                busy
`ifdef MULT_CTRL_FLUSH_EN
    ,
    input  logic                flush
`endif
);

    localparam int CNT_W = (REDUCE_CYCLES > 1) ? $clog2(REDUCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(REDUCE_CYCLES - 1);

    mult_ctrl_state_t  state_q, state_d;
    mult_funct3_t      op_q;
    logic [DATA_W-1:0] rs1_q, rs2_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              flush_i;
    logic              accept;
    logic [DATA_W-1:0] fix_data;

`ifdef MULT_CTRL_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    assign accept = (state_q == ST_IDLE) && bus.req_valid && !flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= F3_MUL;
            rs1_q   <= '0;
            rs2_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= bus.req_op;
                rs1_q <= bus.req_rs1;
                rs2_q <= bus.req_rs2;
            end
            if (state_q == ST_PP) begin
                cnt_q <= CNT_LOAD;
            end else if ((state_q == ST_REDUCE) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        dp_compute_sign = 1'b0;
        dp_flip_rs1     = 1'b0;
        dp_flip_rs2     = 1'b0;
        dp_i_rdy        = 1'b0;
        dp_mult_done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) state_d = ST_SIGN;
            end
            ST_SIGN: begin
                dp_compute_sign = 1'b1;
                dp_flip_rs1     = flip_rs1(op_q, rs1_q[DATA_W-1]);
                dp_flip_rs2     = flip_rs2(op_q, rs2_q[DATA_W-1]);
                state_d         = ST_PP;
            end
            ST_PP: begin
                dp_i_rdy = 1'b1;
                state_d  = ST_REDUCE;
            end
            ST_REDUCE: begin
                if (cnt_q == '0) begin
                    dp_mult_done = 1'b1;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Flush overrides both handshakes, so it is applied after the case.
        if (flush_i) state_d = ST_IDLE;
    end

    mult_result_fix #(
        .DATA_W(DATA_W)
    ) u_fix (
        .op      (op_q),
        .rs1_msb (rs1_q[DATA_W-1]),
        .rs2_msb (rs2_q[DATA_W-1]),
        .prod    (dp_prod),
        .data    (fix_data)
    );

    assign dp_a           = rs1_q;
    assign dp_b           = rs2_q;
    assign bus.req_ready  = (state_q == ST_IDLE);
    assign busy           = (state_q != ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_data  = (state_q == ST_RESP) ? fix_data : '0;

endmodule

// File: tb/tb_mult_ctrl.sv
// Self-checking bench for mult_ctrl: directed cases plus random ops against an
// arithmetic reference model; flush cases build only with MULT_CTRL_FLUSH_EN.
module tb_mult_ctrl;
    import mult_funct3::*;

    localparam int W  = 4;
    localparam int RC = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mult_ctrl_if #(.DATA_W(W)) bus ();

    logic [W-1:0]   dp_a, dp_b;
    logic           dp_compute_sign, dp_flip_rs1, dp_flip_rs2, dp_i_rdy, dp_mult_done;
    logic [2*W-1:0] dp_prod;
    logic           busy;
`ifdef MULT_CTRL_FLUSH_EN
    logic           flush = 1'b0;
`endif

    mult_ctrl #(.DATA_W(W), .REDUCE_CYCLES(RC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .dp_a            (dp_a),
        .dp_b            (dp_b),
        .dp_compute_sign (dp_compute_sign),
        .dp_flip_rs1     (dp_flip_rs1),
        .dp_flip_rs2     (dp_flip_rs2),
        .dp_i_rdy        (dp_i_rdy),
        .dp_mult_done    (dp_mult_done),
        .dp_prod         (dp_prod),
        .busy            (busy)
`ifdef MULT_CTRL_FLUSH_EN
        ,
        .flush           (flush)
`endif
    );

    // Datapath stand-in: multiplies operand magnitudes using the flips it saw.
    logic f1_seen = 1'b0, f2_seen = 1'b0;
    logic [W-1:0] a_mag, b_mag;
    always @(posedge clk) begin
        if (dp_compute_sign) begin
            f1_seen <= dp_flip_rs1;
            f2_seen <= dp_flip_rs2;
        end
    end
    always_comb begin
        a_mag   = f1_seen ? -dp_a : dp_a;
        b_mag   = f2_seen ? -dp_b : dp_b;
        dp_prod = {{W{1'b0}}, a_mag} * {{W{1'b0}}, b_mag};
    end

    logic [4:0] strobes;
    assign strobes = {dp_compute_sign, dp_flip_rs1, dp_flip_rs2, dp_i_rdy, dp_mult_done};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: full-precision products with the operand signedness of each op.
    function automatic logic [W-1:0] ref_result(input mult_funct3_t op,
                                                input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, ua, ub, p;
        logic [63:0] pv;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        case (op)
            F3_MUL, F3_MULH: p = sa * sb;
            F3_MULHSU:       p = sa * ub;
            default:         p = ua * ub;
        endcase
        pv = p;
        return (op == F3_MUL) ? pv[W-1:0] : pv[2*W-1:W];
    endfunction

    function automatic logic exp_f1(input mult_funct3_t op, input logic [W-1:0] a);
        return (op == F3_MULHU) ? 1'b0 : a[W-1];
    endfunction

    function automatic logic exp_f2(input mult_funct3_t op, input logic [W-1:0] b);
        return (op == F3_MUL || op == F3_MULH) ? b[W-1] : 1'b0;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_resp_valid"}, bus.resp_valid, 0);
        chk({tag, "_resp_data"}, bus.resp_data, 0);
        chk({tag, "_strobes"}, strobes, 0);
    endtask

    // One full transaction; junk=1 keeps req_valid high with other operands while busy.
    task automatic run_op(input mult_funct3_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, input bit junk);
        logic [W-1:0] expd;
        expd = ref_result(op, a, b);
        @(negedge clk);
        chk("accept_ready", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_rs1   = a;
        bus.req_rs2   = b;
        @(negedge clk);
        if (junk) begin
            bus.req_op  = mult_funct3_t'(3'($urandom_range(0, 3)));
            bus.req_rs1 = W'($urandom);
            bus.req_rs2 = W'($urandom);
        end else begin
            bus.req_valid = 1'b0;
        end
        chk("sign_strobes", strobes, {1'b1, exp_f1(op, a), exp_f2(op, b), 2'b00});
        chk("sign_busy", busy, 1);
        chk("sign_req_ready", bus.req_ready, 0);
        chk("dp_a", dp_a, a);
        chk("dp_b", dp_b, b);
        @(negedge clk);
        chk("pp_strobes", strobes, 5'b00010);
        chk("pp_resp_valid", bus.resp_valid, 0);
        for (int r = 0; r < RC; r++) begin
            @(negedge clk);
            chk("reduce_strobes", strobes, {4'b0000, (r == RC - 1) ? 1'b1 : 1'b0});
            chk("reduce_resp_valid", bus.resp_valid, 0);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("resp_valid", bus.resp_valid, 1);
        chk("resp_data", bus.resp_data, expd);
        chk("resp_strobes", strobes, 0);
        chk("resp_req_ready", bus.req_ready, 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", bus.resp_valid, 1);
            chk("hold_data", bus.resp_data, expd);
            chk("hold_req_ready", bus.req_ready, 0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        chk("exit_resp_valid", bus.resp_valid, 0);
        chk("exit_req_ready", bus.req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_op     = F3_MUL;
        bus.req_rs1    = '0;
        bus.req_rs2    = '0;
        bus.resp_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check_idle("reset");
        chk("reset_dp_a", dp_a, 0);
        chk("reset_dp_b", dp_b, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(F3_MUL,    4'h3, 4'h5, 0, 1'b0);
        run_op(F3_MULH,   4'h8, 4'h8, 0, 1'b0);
        run_op(F3_MUL,    4'h8, 4'h8, 0, 1'b0);
        run_op(F3_MULHSU, 4'hF, 4'hF, 0, 1'b0);
        run_op(F3_MUL,    4'hF, 4'hF, 0, 1'b0);
        run_op(F3_MULHU,  4'hF, 4'hF, 3, 1'b0);

        // Reset during REDUCE discards the operation.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = F3_MULH;
        bus.req_rs1   = 4'h7;
        bus.req_rs2   = 4'h9;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_done", dp_mult_done, 1);
        #1 rst_n = 1'b0;
        #1;
        check_idle("midreset");
        chk("midreset_dp_a", dp_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_reset");
        @(negedge clk);
        check_idle("post_reset2");
        run_op(F3_MULH, 4'h7, 4'h9, 1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(mult_funct3_t'(3'($urandom_range(0, 3))), W'($urandom), W'($urandom),
                   int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

`ifdef MULT_CTRL_FLUSH_EN
        // Flush in PP.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = F3_MUL;
        bus.req_rs1   = 4'h3;
        bus.req_rs2   = 4'h3;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("flush_pp_irdy", dp_i_rdy, 1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check_idle("flush_pp");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("flush_pp_no_resp", bus.resp_valid, 0);
        end
        // Flush in RESP together with resp_ready.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = F3_MULHU;
        bus.req_rs1   = 4'h5;
        bus.req_rs2   = 4'h6;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (2 + RC) @(negedge clk);
        chk("flush_resp_valid", bus.resp_valid, 1);
        flush = 1'b1;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.resp_ready = 1'b0;
        check_idle("flush_resp");
        // Flush beats a same-cycle request.
        @(negedge clk);
        bus.req_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.req_valid = 1'b0;
        check_idle("flush_idle");
        run_op(F3_MUL, 4'h3, 4'h5, 0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
